vga_line_fetch: RTL and testbench
=================================

# vga_line_fetch

Framebuffer line fetcher and pixel upscaler that sits directly upstream of the VGA timing controller. It fetches low-resolution source rows (RGB565) from framebuffer memory into a ping-pong line buffer and returns `pix_data` for the `pix_x`/`pix_y` coordinates the controller requests. Each source pixel is replicated 2^SCALE_SHIFT times horizontally and vertically, so the output fills 640x480.

## Interface
- `SCALE_SHIFT`, default 1: upscale factor log2. Valid values are 1 (320x240 source) and 2 (160x120 source). SRC_W = 640>>SCALE_SHIFT, SRC_H = 480>>SCALE_SHIFT.
- `ADDR_W`, default 17: width of the framebuffer word address.
- `FB_BASE`, default 0: word address of source pixel (0,0). The framebuffer is row-major with a stride of SRC_W.

Ports:
- `vga_clk`  in  1  pixel clock, 25 MHz.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `pix_x`  in  10  requested column. 0x3FF means outside the active area.
- `pix_y`  in  10  requested row. 0x3FF means outside the active area.
- `vsync`  in  1  field sync from the timing controller, active low.
- `pix_data`  out  16  RGB565 pixel for the previous cycle's request.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read word address.
- `mem_ack`  in  1  request accepted this cycle (only meaningful while `mem_req` is high).
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  16  read data.
- `underrun`  out  1  sticky flag: a display line started before its source row was complete.

## Operation
- **Line buffer:** 2 banks of SRC_W x 16 bits. Writes are synchronous. Reads are synchronous with 1-cycle latency. Two bank pointers, `fill_bank` and `disp_bank`, select which bank is being written and which is being displayed.
- **Frame start:** a falling edge of `vsync` is detected from a registered copy of `vsync`. On that edge:
  - `fill_bank` <= 0.
  - A fetch of source row 0 starts.
  - `underrun` is cleared.
- **Line start:** a line start is a cycle where `pix_x`==0, `pix_y`!=0x3FF, and `pix_y[SCALE_SHIFT-1:0]`==0. On a line start:
  - `disp_bank` <= `fill_bank`.
  - `fill_bank` <= ~`fill_bank`.
  - If (`pix_y`>>SCALE_SHIFT)+1 < SRC_H, a fetch of that row starts. Otherwise no fetch starts.
- **Fetch FSM states:**
  - IDLE: when a fetch starts, load `row` and set `col`=0, then go to REQ.
  - REQ: `mem_req`=1 and `mem_addr`=FB_BASE+row*SRC_W+col, both held stable until `mem_ack`. Then go to WAIT.
  - WAIT: on `mem_rvalid`, write `mem_rdata` to [`fill_bank`][`col`]. If `col`==SRC_W-1, go to IDLE. Otherwise `col`++ and go to REQ.
  - At most one transaction is outstanding at any time.
- **Start while busy:** a fetch start (vsync edge or line start) while the FSM is not IDLE:
  - `underrun` is set when `UNDERRUN_EN` is compiled in.
  - An accepted-but-unreturned read still completes. Its data is discarded (no buffer write).
  - A REQ not yet acked is dropped only after `mem_ack`. `mem_req` never deasserts before ack.
  - The new row is latched and its fetch begins from `col`=0 once the outstanding handshake closes.
- **Pixel path:**
  - `pix_data` <= 0 if `pix_x`==0x3FF or `pix_y`==0x3FF.
  - Otherwise `pix_data` <= buffer[bank][`pix_x`>>SCALE_SHIFT].
  - On a line-start cycle, `bank` is the new `disp_bank` value (bypass of the register update).
  - Out-of-range `pix_x` values (640..0x3FE) return 0.
- **Arithmetic:** `mem_addr` is computed modulo 2^ADDR_W. The row*SRC_W product is formed at ADDR_W bits.

## Timing
- Reset values: `pix_data`=0, `mem_req`=0, `mem_addr`=0, `underrun`=0. The FSM is IDLE, both banks pointers are 0, and the registered `vsync` copy is 1.
- `pix_data` latency is exactly 1 cycle from `pix_x`/`pix_y`.
- The vsync falling edge acts 1 cycle after `vsync` is sampled low.
- Per-word cost is at least 2 cycles (REQ plus WAIT).
- Budget: with SCALE_SHIFT=1, each row must complete within 1600 cycles, which allows a memory turnaround of up to 3 cycles per word without underrun.
- If reset is asserted mid-fetch, all state clears immediately. Memory side effects of an in-flight read are ignored.
- Buffer contents are not reset. Pixels may be stale until the first fetch completes.

## Configuration
- Macro: `VGA_LINE_FETCH_UNDERRUN_EN`.
- Defined: `underrun` detection as described above.
- Undefined: `underrun` is tied to 0. All fetch behaviour, including discard and restart, is unchanged.

## Test plan
1. Reset, then a `vsync` fall, with memory giving `mem_ack` immediately and `mem_rvalid` 1 cycle later. Required: `mem_addr` sequence 0..319 for row 0, then `mem_req`=0.
2. Fill row 0 with value = column index, then drive `pix_y`=0 and `pix_x`=0..639. Required: `pix_data` = `pix_x`>>1, 1 cycle later.
3. Line start at `pix_y`=2 after row 1 has completed. Required: banks swap, the fetch of row 2 starts at address 640, and pixels show row 1's data.
4. Memory stalled with `mem_ack`=0 at the next line start. Required: `mem_req` and `mem_addr` stay stable, `underrun`=1, then the fetch restarts at `col`=0 of the new row.
5. `pix_x`=0x3FF or `pix_y`=0x3FF. Required: `pix_data`=0. `pix_y`=478 line start (SCALE_SHIFT=1): no fetch starts.
6. Assert `sys_rst_n` low mid-WAIT. Required: `mem_req`=0, `pix_data`=0, `underrun`=0 asynchronously.

Source files
------------

// File: rtl/vga_line_fetch.sv
// Framebuffer row fetcher with a ping-pong line buffer and 2^SCALE_SHIFT pixel replication.
// Optional feature macro: VGA_LINE_FETCH_UNDERRUN_EN enables the sticky underrun flag.
module vga_line_fetch #(
    parameter int          SCALE_SHIFT = 1,
    parameter int          ADDR_W      = 17,
    parameter int unsigned FB_BASE     = 0
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              vsync,
    output logic [15:0]       pix_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              underrun
);

    localparam int                SRC_W     = 640 >> SCALE_SHIFT;
    localparam int                SRC_H     = 480 >> SCALE_SHIFT;
    localparam int                BUF_D     = 2 * SRC_W;
    localparam logic [9:0]        COORD_OFF = 10'h3FF;
    localparam logic [9:0]        ACT_W     = 10'd640;
    localparam logic [9:0]        SRC_W_V   = 10'(SRC_W);
    localparam logic [9:0]        SRC_H_V   = 10'(SRC_H);
    localparam logic [9:0]        LOW_MASK  = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(SRC_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              vsync_r;
    logic              fill_bank_r;
    logic              disp_bank_r;
    logic [9:0]        row_r;
    logic [9:0]        row_s;
    logic [9:0]        col_r;
    logic [9:0]        col_s;
    logic              discard_r;
    logic              discard_s;
    logic              load_addr_s;
    logic              wr_en_s;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] next_addr_s;
    logic [15:0]       pix_data_r;
    logic              underrun_r;
    logic              underrun_set_s;

    logic              frame_start_s;
    logic              line_start_s;
    logic [9:0]        line_row_s;
    logic              line_fetch_s;
    logic              fetch_start_s;
    logic [9:0]        start_row_s;
    logic              busy_s;

    logic              rd_bank_s;
    logic [9:0]        rd_col_s;
    logic [9:0]        rd_idx_s;
    logic [9:0]        wr_idx_s;
    logic              pix_blank_s;

    logic [15:0]       line_buf [0:BUF_D-1];

    assign frame_start_s = vsync_r & ~vsync;
    assign line_start_s  = (pix_x == 10'd0) && (pix_y != COORD_OFF) &&
                           ((pix_y & LOW_MASK) == 10'd0);
    assign line_row_s    = (pix_y >> SCALE_SHIFT) + 10'd1;
    assign line_fetch_s  = line_start_s && (line_row_s < SRC_H_V);
    assign fetch_start_s = frame_start_s | line_fetch_s;
    assign start_row_s   = frame_start_s ? 10'd0 : line_row_s;
    assign busy_s        = (state_r != ST_IDLE);

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    assign underrun_set_s = fetch_start_s & busy_s;
`else
    assign underrun_set_s = 1'b0;
`endif

    // Fetch FSM next state; a restart while busy retargets row/col and discards the in-flight word
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = col_r;
        discard_s   = discard_r;
        load_addr_s = 1'b0;
        wr_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_start_s) begin
                    row_s       = start_row_s;
                    col_s       = 10'd0;
                    discard_s   = 1'b0;
                    state_s     = ST_REQ;
                    load_addr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (fetch_start_s) begin
                    row_s     = start_row_s;
                    col_s     = 10'd0;
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
                if (mem_ack) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (fetch_start_s) begin
                    row_s = start_row_s;
                    col_s = 10'd0;
                    if (mem_rvalid) begin
                        discard_s   = 1'b0;
                        state_s     = ST_REQ;
                        load_addr_s = 1'b1;
                    end else begin
                        discard_s = 1'b1;
                        state_s   = ST_WAIT;
                    end
                end else if (mem_rvalid) begin
                    if (discard_r) begin
                        discard_s   = 1'b0;
                        state_s     = ST_REQ;
                        load_addr_s = 1'b1;
                    end else if (col_r == (SRC_W_V - 10'd1)) begin
                        wr_en_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        wr_en_s     = 1'b1;
                        col_s       = col_r + 10'd1;
                        state_s     = ST_REQ;
                        load_addr_s = 1'b1;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                discard_s = 1'b0;
            end
        endcase
    end

    assign next_addr_s = BASE_A + (ADDR_W'(row_s) * STRIDE_A) + ADDR_W'(col_s);

    // Fetch state, counters and memory request outputs
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            row_r      <= 10'd0;
            col_r      <= 10'd0;
            discard_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_s;
            row_r     <= row_s;
            col_r     <= col_s;
            discard_r <= discard_s;
            mem_req_r <= (state_s == ST_REQ);
            if (load_addr_s) begin
                mem_addr_r <= next_addr_s;
            end
        end
    end

    // Vsync edge history, bank pointers and sticky underrun
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_r     <= 1'b1;
            fill_bank_r <= 1'b0;
            disp_bank_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            vsync_r <= vsync;
            if (line_start_s) begin
                disp_bank_r <= fill_bank_r;
            end
            if (frame_start_s) begin
                fill_bank_r <= 1'b0;
            end else if (line_start_s) begin
                fill_bank_r <= ~fill_bank_r;
            end
            if (frame_start_s) begin
                underrun_r <= 1'b0;
            end else if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign wr_idx_s    = fill_bank_r ? (SRC_W_V + col_r) : col_r;
    // A line-start cycle reads the bank that is about to become the display bank
    assign rd_bank_s   = line_start_s ? fill_bank_r : disp_bank_r;
    assign rd_col_s    = pix_x >> SCALE_SHIFT;
    assign pix_blank_s = (pix_x == COORD_OFF) || (pix_y == COORD_OFF) || (pix_x >= ACT_W);
    assign rd_idx_s    = pix_blank_s ? 10'd0 :
                         (rd_bank_s ? (SRC_W_V + rd_col_s) : rd_col_s);

    // Line buffer write port; contents are deliberately not reset
    always_ff @(posedge vga_clk) begin
        if (wr_en_s) begin
            line_buf[wr_idx_s] <= mem_rdata;
        end
    end

    // Registered pixel read with blanking outside the active area
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_r <= 16'd0;
        end else if (pix_blank_s) begin
            pix_data_r <= 16'd0;
        end else begin
            pix_data_r <= line_buf[rd_idx_s];
        end
    end

    assign pix_data = pix_data_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign underrun = underrun_r;

    vga_line_fetch_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .mem_req   (mem_req_r),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr_r),
        .state     (state_r)
    );

endmodule

module vga_line_fetch_chk #(
    parameter int ADDR_W = 17
) (
    input logic              vga_clk,
    input logic              sys_rst_n,
    input logic              mem_req,
    input logic              mem_ack,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [1:0]        state
);

    a_req_hold: assert property (@(posedge vga_clk) disable iff (!sys_rst_n)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

    a_state_legal: assert property (@(posedge vga_clk) disable iff (!sys_rst_n)
        (state != 2'd3));

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch (SCALE_SHIFT=1, FB_BASE=0); memory returns data = word address.
module tb_vga_line_fetch;

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        vsync;
    logic [15:0] pix_data;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        underrun;

    logic        ack_en;
    logic        acc_pend;
    logic [16:0] acc_addr;
    logic [16:0] acc_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    vga_line_fetch dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .vsync      (vsync),
        .pix_data   (pix_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .underrun   (underrun)
    );

    initial begin
        forever #20 vga_clk = ~vga_clk;
    end

    // Memory: ack in the request cycle, data one cycle after the handshake
    initial begin
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'd0;
        acc_pend   = 1'b0;
        acc_addr   = 17'd0;
        forever begin
            @(negedge vga_clk);
            #2;
            if (acc_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = acc_addr[15:0];
                acc_pend   = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (mem_req && ack_en && sys_rst_n) begin
                mem_ack  = 1'b1;
                acc_pend = 1'b1;
                acc_addr = mem_addr;
                acc_q.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < acc_q.size()) return 32'(acc_q[i]);
        else return 32'hFFFF_FFFF;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, output logic [15:0] d);
        pix_x = x;
        pix_y = y;
        @(negedge vga_clk);
        d = pix_data;
    endtask

    task automatic go_idle();
        pix_x = 10'h3FF;
        pix_y = 10'h3FF;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && acc_q.size() < n; i++) @(negedge vga_clk);
        check_eq(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        int          q0;
        logic        found;

        sys_rst_n = 1'b0;
        vsync     = 1'b1;
        ack_en    = 1'b1;
        go_idle();
        cycles(3);
        check_eq("rst_pix", 32'(pix_data), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        sys_rst_n = 1'b1;
        cycles(3);
        check_eq("idle_no_req", 32'(mem_req), 32'd0);

        // Frame start fetches row 0
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        wait_acc(320, 1500, "row0_done");
        cycles(4);
        for (int i = 0; i < 320; i++) check_eq("row0_addr", q_at(i), 32'(i));
        check_eq("row0_count", 32'(acc_q.size()), 32'd320);
        check_eq("row0_req_off", 32'(mem_req), 32'd0);

        // Display row 0 at pix_y=0; this line start fetches row 1
        for (int x = 0; x < 640; x++) begin
            drive_pix(10'(x), 10'd0, d);
            check_eq("row0_pix", 32'(d), 32'(x >> 1));
        end
        go_idle();
        wait_acc(640, 1000, "row1_done");
        cycles(4);
        check_eq("row1_first", q_at(320), 32'd320);
        check_eq("row1_last", q_at(639), 32'd639);

        // pix_y=1 is not a line start: still row 0
        drive_pix(10'd0, 10'd1, d);   check_eq("y1_x0", 32'(d), 32'd0);
        drive_pix(10'd5, 10'd1, d);   check_eq("y1_x5", 32'(d), 32'd2);
        drive_pix(10'd639, 10'd1, d); check_eq("y1_x639", 32'(d), 32'd319);
        drive_pix(10'd640, 10'd1, d); check_eq("x640_blank", 32'(d), 32'd0);
        drive_pix(10'h3FE, 10'd1, d); check_eq("x3fe_blank", 32'(d), 32'd0);

        // Line start at pix_y=2 swaps banks and fetches row 2
        for (int x = 0; x < 10; x++) begin
            drive_pix(10'(x), 10'd2, d);
            check_eq("row1_pix", 32'(d), 32'(320 + (x >> 1)));
        end
        go_idle();
        wait_acc(641, 50, "row2_start");
        check_eq("row2_addr", q_at(640), 32'd640);
        wait_acc(960, 1000, "row2_done");
        cycles(4);

        // Stalled memory across a line start
        ack_en = 1'b0;
        drive_pix(10'd0, 10'd4, d);
        check_eq("row2_pix", 32'(d), 32'd640);
        go_idle();
        cycles(3);
        check_eq("stall_req", 32'(mem_req), 32'd1);
        check_eq("stall_addr", 32'(mem_addr), 32'd960);
        q0 = acc_q.size();
        drive_pix(10'd0, 10'd6, d);
        go_idle();
        check_eq("underrun_set", 32'(underrun), 32'(UR_EXP));
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check_eq("hold_req", 32'(mem_req), 32'd1);
            check_eq("hold_addr", 32'(mem_addr), 32'd960);
        end
        ack_en = 1'b1;
        wait_acc(q0 + 2, 50, "restart");
        check_eq("dropped_addr", q_at(q0), 32'd960);
        check_eq("restart_addr", q_at(q0 + 1), 32'd1280);
        wait_acc(q0 + 321, 1000, "row4_done");
        cycles(4);
        check_eq("row4_req_off", 32'(mem_req), 32'd0);
        drive_pix(10'd0, 10'd8, d); check_eq("row4_pix0", 32'(d), 32'd1280);
        drive_pix(10'd2, 10'd8, d); check_eq("row4_pix2", 32'(d), 32'd1281);
        go_idle();
        wait_acc(q0 + 641, 1000, "row5_done");
        cycles(4);
        check_eq("underrun_sticky", 32'(underrun), 32'(UR_EXP));

        // Blanking and last-row boundary
        drive_pix(10'h3FF, 10'd0, d); check_eq("x3ff_blank", 32'(d), 32'd0);
        drive_pix(10'd5, 10'h3FF, d); check_eq("y3ff_blank", 32'(d), 32'd0);
        q0 = acc_q.size();
        drive_pix(10'd0, 10'd476, d);
        go_idle();
        wait_acc(q0 + 1, 20, "row239_start");
        check_eq("row239_addr", q_at(q0), 32'd76480);
        wait_acc(q0 + 320, 1000, "row239_done");
        cycles(4);
        q0 = acc_q.size();
        drive_pix(10'd0, 10'd478, d);   check_eq("row239_pix0", 32'(d), 32'd10944);
        drive_pix(10'd2, 10'd478, d);   check_eq("row239_pix2", 32'(d), 32'd10945);
        drive_pix(10'd639, 10'd478, d); check_eq("row239_pix639", 32'(d), 32'd11263);
        go_idle();
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check_eq("y478_no_req", 32'(mem_req), 32'd0);
        end
        check_eq("y478_no_fetch", 32'(acc_q.size()), 32'(q0));

        // New frame clears underrun; reset lands mid-WAIT
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        wait_acc(q0 + 3, 50, "frame2_start");
        check_eq("frame_row0_addr", q_at(q0), 32'd0);
        check_eq("underrun_clr", 32'(underrun), 32'd0);
        drive_pix(10'd100, 10'd1, d);
        check_eq("stale_pix", 32'(d), 32'd10994);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge vga_clk);
            #5;
            if (!mem_req) found = 1'b1;
        end
        check_eq("found_wait", 32'(found), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check_eq("async_rst_req", 32'(mem_req), 32'd0);
        check_eq("async_rst_pix", 32'(pix_data), 32'd0);
        check_eq("async_rst_underrun", 32'(underrun), 32'd0);
        check_eq("async_rst_addr", 32'(mem_addr), 32'd0);
        cycles(2);
        sys_rst_n = 1'b1;
        go_idle();
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
